// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, port IDs, widths.
package dmem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way request picker with optional round-robin tie-break.
import dmem_pkg::*;

module rr_pick2 #(
    parameter bit RR = 1'b1
) (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_id,
    output logic gnt_valid
);

    // Pick a port: single requester wins outright, ties go opposite last_gnt (RR) or to CPU.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = PORT_CPU;
        if (req0 && req1) begin
            gnt_id = RR ? ~last_gnt : PORT_CPU;
        end else if (req1) begin
            gnt_id = PORT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter and access sequencer sharing one data memory between the CPU and a debug/loader port.
import dmem_pkg::*;

module dmem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int RR      = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [BE_W-1:0]   cpu_be,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [BE_W-1:0]   dbg_be,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam int                 CNT_W  = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0]   LAT_M1 = CNT_W'(MEM_LAT - 1);

    state_t              state;
    state_t              state_next;
    logic                last_gnt;
    logic                gnt_id;
    logic                pick_id;
    logic                pick_valid;
    logic                lat_we;
    logic [ADDR_W-3:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [BE_W-1:0]     lat_be;
    logic [CNT_W-1:0]    cnt;
    logic                unused_addr_lsbs;

    // Byte-offset bits never reach memory; the access is always word-aligned.
    assign unused_addr_lsbs = ^{cpu_addr[1:0], dbg_addr[1:0]};

    rr_pick2 #(
        .RR (RR != 0)
    ) u_pick (
        .req0      (cpu_req),
        .req1      (dbg_req),
        .last_gnt  (last_gnt),
        .gnt_id    (pick_id),
        .gnt_valid (pick_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant latching, latency counting, read-data capture and last-grant tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_id    <= PORT_CPU;
            last_gnt  <= PORT_DBG;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            cnt       <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_id <= pick_id;
                        if (pick_id == PORT_DBG) begin
                            lat_we    <= dbg_we;
                            lat_addr  <= dbg_addr[ADDR_W-1:2];
                            lat_wdata <= dbg_wdata;
                            lat_be    <= dbg_be;
                        end else begin
                            lat_we    <= cpu_we;
                            lat_addr  <= cpu_addr[ADDR_W-1:2];
                            lat_wdata <= cpu_wdata;
                            lat_be    <= cpu_be;
                        end
                    end
                end
                ISSUE: cnt <= LAT_M1;
                WAIT: begin
                    if (cnt == '0) begin
                        if (!lat_we) begin
                            if (gnt_id == PORT_DBG) dbg_rdata <= mem_rdata;
                            else                    cpu_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP:    last_gnt <= gnt_id;
                default: ;
            endcase
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & lat_we;
    assign mem_addr  = {lat_addr, 2'b00};
    assign mem_wdata = lat_wdata;
    assign mem_be    = lat_be;
    assign cpu_done  = (state == RESP) && (gnt_id == PORT_CPU);
    assign dbg_done  = (state == RESP) && (gnt_id == PORT_DBG);
    assign cpu_stall = cpu_req & ~cpu_done;
    assign busy      = (state != IDLE);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-port, byte-addressed data memory (`data_mem`). It shares that memory between two requesters:

- the CPU load/store path;
- a debug/loader port, which pre-loads or inspects memory while the core runs.

The block serialises accesses, handles fixed memory read latency, and stalls the CPU until its access completes.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles from `mem_en` until `mem_rdata` is valid (≥1).
- `RR`, default 1: 1 = round-robin between ports; 0 = CPU always wins ties.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `cpu_req` input 1: CPU access request; held high until `cpu_done`.
- `cpu_we` input 1: 1 = store, 0 = load.
- `cpu_addr` input 32: byte address; bits [1:0] ignored.
- `cpu_wdata` input 32: store data.
- `cpu_be` input 4: byte enables for stores.
- `cpu_rdata` output 32: registered load data, valid while `cpu_done`.
- `cpu_done` output 1: one-cycle completion pulse.
- `cpu_stall` output 1: `cpu_req & ~cpu_done`, combinational.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_be`, `dbg_rdata`, `dbg_done`: same widths and meaning as the `cpu_*` ports.
- `mem_en` output 1: one-cycle access strobe to memory.
- `mem_we` output 1: write strobe, qualified by `mem_en`.
- `mem_addr` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` output 32: write data.
- `mem_be` output 4: byte enables.
- `mem_rdata` input 32: memory read data, valid `MEM_LAT` cycles after `mem_en`.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE:** samples `cpu_req`/`dbg_req`.
  - One request active: grant it.
  - Both active:
    - `RR`=1: grant the port opposite `last_gnt`.
    - `RR`=0: grant CPU.
  - On a grant, latch the granted port's `we`/`addr`/`wdata`/`be` and `gnt_id`; go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** `mem_en`=1 for exactly this cycle, with the latched fields driven on the `mem_*` outputs. Load the wait counter with `MEM_LAT`-1; go to WAIT.
- **WAIT:** decrement the counter.
  - Counter at 0: capture `mem_rdata` into the granted port's rdata register (loads only; stores leave rdata unchanged), then go to RESP.
  - `MEM_LAT`=1: WAIT lasts exactly one cycle.
- **RESP:** pulse the granted port's `done`, set `last_gnt`=`gnt_id`, go to IDLE.
- Requester rule: after `done`, the requester either drops `req` or presents the next access. IDLE samples the following cycle.
- Request dropped or changed mid-access is a protocol violation. The arbiter still completes the latched access from the latched fields and pulses `done`.
- The non-granted port's `done` stays 0 throughout. Its request waits and is served in the next IDLE.

## Timing
- Reset (synchronous):
  - state = IDLE, `last_gnt` = dbg (so CPU wins the first tie);
  - `cpu_done`, `dbg_done`, `mem_en`, `mem_we`, `busy` = 0;
  - `cpu_rdata`, `dbg_rdata`, `mem_addr`, `mem_wdata`, `mem_be` = 0.
- Latency: request seen in IDLE at cycle T → `mem_en` at T+1 → rdata captured at T+1+`MEM_LAT` → `done` at T+2+`MEM_LAT`.
- Throughput: one access per `MEM_LAT`+3 cycles; the next IDLE sample is at T+3+`MEM_LAT`.
- Reset mid-access aborts the access: no `done`, `mem_en` drops the next cycle, and late `mem_rdata` is ignored.
- Counter width: $clog2(`MEM_LAT`)+1. No wrap: the counter is reloaded only in ISSUE.

## Structure
- Shared package `dmem_pkg` holds:
  - FSM state enum (IDLE/ISSUE/WAIT/RESP);
  - port IDs `PORT_CPU`=0, `PORT_DBG`=1;
  - address width 32 and byte-enable width 4.
- One sub-module, `rr_pick2`: combinational 2-way pick from (`req0`, `req1`, `last_gnt`, `RR`) returning `gnt_id` and `gnt_valid`.

## Test plan
- Single CPU load, `MEM_LAT`=1: `cpu_req`=1, `cpu_addr`=0x0000000E, memory word 0x0000000C holds 0x07060504.
  - Required: `mem_addr`=0x0000000C, `mem_en` at T+1, `cpu_done` at T+3, `cpu_rdata`=0x07060504.
  - Required: `cpu_stall`=1 during T..T+2.
- CPU store: `cpu_we`=1, `be`=4'b0011, `wdata`=0x0000000F, `addr`=0x00000008.
  - Required: `mem_we`=1, `mem_be`=0011, `mem_wdata`=0x0000000F on the single `mem_en` cycle.
  - Required: a following load returns 0x0000000F in the low half.
- Simultaneous `cpu_req` and `dbg_req`, both held, `RR`=1.
  - Required: grant order CPU, DBG, CPU, DBG; `done` pulses 4 cycles apart; never two `done` in one cycle.
- Same contention with `RR`=0.
  - Required: CPU served every access while `cpu_req` stays high; DBG served only after `cpu_req` drops.
- `MEM_LAT`=3, debug load of 0xDEADBEEF.
  - Required: `dbg_done` exactly 5 cycles after the IDLE sample; `dbg_rdata`=0xDEADBEEF.
- Reset asserted in WAIT.
  - Required: no `done` pulse; all outputs zero the cycle after reset.
  - Required: the next CPU request completes normally with fresh data.
